// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart-side handshake bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport, the surrounding system through master.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               tx_start;
  logic [DW-1:0]      tx_data;
  logic               tx_done;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart transmitter among NREQ byte sources, with a
// start/done handshake sequencer and a watchdog that aborts a transfer whose done never arrives.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WW     = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t        state, state_nx;
  logic          tx_start_q, tx_start_nx;
  logic [DW-1:0] tx_data_q, tx_data_nx;
  logic [GW-1:0] grant_q, grant_nx;
  logic [GW-1:0] rr_ptr, rr_ptr_nx;
  logic [WW-1:0] wdog, wdog_nx;
  logic          err_q, err_nx;

  logic          found;
  logic [GW-1:0] winner;
  logic [DW-1:0] win_data;

  // Rotating priority search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found  = 1'b1;
        winner = GW'((int'(rr_ptr) + k) % NREQ);
      end
    end
    win_data = bus.req_data[int'(winner)*DW +: DW];
  end

  assign bus.req_ready = (rst && state == IDLE && found) ? (NREQ'(1) << winner) : '0;

  always_comb begin
    state_nx    = state;
    tx_start_nx = tx_start_q;
    tx_data_nx  = tx_data_q;
    grant_nx    = grant_q;
    rr_ptr_nx   = rr_ptr;
    wdog_nx     = wdog;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_nx  = win_data;
          tx_start_nx = 1'b1;
          grant_nx    = winner;
          rr_ptr_nx   = (winner == GW'(NREQ-1)) ? '0 : winner + GW'(1);
          wdog_nx     = '0;
          state_nx    = SEND;
        end
      end
      SEND: begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (bus.tx_done) begin
          tx_start_nx = 1'b0;
          state_nx    = RELEASE;
        end else if (wdog == WW'(TIMEOUT-1)) begin
          tx_start_nx = 1'b0;
          err_nx      = 1'b1;
          state_nx    = RELEASE;
        end else begin
          wdog_nx = wdog + WW'(1);
        end
      end
      RELEASE: begin
        if (!bus.tx_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      rr_ptr     <= '0;
      wdog       <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      tx_start_q <= tx_start_nx;
      tx_data_q  <= tx_data_nx;
      grant_q    <= grant_nx;
      rr_ptr     <= rr_ptr_nx;
      wdog       <= wdog_nx;
      err_q      <= err_nx;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign grant_id     = grant_q;
  assign busy         = (state != IDLE);
  assign timeout_err  = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart transmitter among NREQ independent byte sources using round-robin arbitration. Sequences the uart tx handshake: tx_start is held high with stable tx_data until tx_done, then released. A watchdog aborts a transfer whose tx_done never arrives. Sits between the application producers and the uart instance, in the uart clock domain.

Parameters:
NREQ, 4, number of requesters (1..8)
DW, 8, data width per requester
TIMEOUT, 4096, uartclk cycles allowed in SEND before abort (>=2)

Ports:
clk  input  1  uart clock; all logic on posedge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  NREQ  requester i has a byte pending
req_data  input  NREQ*DW  byte of requester i at bits [i*DW +: DW]
req_ready  output  NREQ  one-hot accept; byte of i is taken at the edge where valid[i]&ready[i]
tx_start  output  1  to uart tx_start
tx_data  output  DW  to uart tx_data
tx_done  input  1  from uart tx_done
grant_id  output  clog2(NREQ) (min 1)  index of the last granted requester
busy  output  1  high in SEND or RELEASE
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_start=0, tx_data=0, grant_id=0, rr_ptr=0, wdog=0, timeout_err=0. req_ready=0 while in reset. All registered outputs come out of reset in these values on the first edge after rst rises.
- States: IDLE, SEND, RELEASE. busy = (state != IDLE).
- req_ready is combinational. Outside IDLE it is all zeros. In IDLE it is one-hot on the winner: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap at NREQ. It is all zeros if no valid is high.
- IDLE, winner g exists, at the edge:
  - tx_data <= req_data[g], tx_start <= 1, grant_id <= g.
  - rr_ptr <= (g+1) mod NREQ, wdog <= 0, state <= SEND.
  - Latency: valid sampled at edge k gives tx_start=1 after edge k.
- SEND:
  - tx_start stays 1 and tx_data stays stable; wdog increments each cycle.
  - tx_done=1: tx_start <= 0, state <= RELEASE.
  - tx_done=0 and wdog == TIMEOUT-1: tx_start <= 0, timeout_err <= 1 for one cycle, state <= RELEASE.
  - If tx_done=1 in the same cycle that wdog hits TIMEOUT-1, tx_done wins and there is no error.
- RELEASE: tx_start=0. When tx_done=0, state <= IDLE. This guarantees the uart's done from the previous byte is never taken for the next. Minimum spacing between bytes: SEND(>=1) + RELEASE(>=1) + IDLE(1) cycles.
- Requester rules:
  - A requester may drop valid before ready with no side effects.
  - A requester that keeps valid high after acceptance is re-arbitrated as a new byte.
  - req_data is sampled only on the accept edge.
- Fairness: with all valid permanently high, grants run 0,1,...,NREQ-1,0,... No requester waits more than NREQ-1 other grants.
- rr_ptr advances only on a grant. A timed-out transfer still counts as that requester's grant; the byte is dropped, not retried.
- NREQ=1: grant_id is constant 0 and arbitration degenerates to pass-through.
- Reset mid-transfer: tx_start drops immediately (asynchronously) and the pending byte is discarded.

Test Plan:
1. Single requester: NREQ=4, valid[2]=1, data=0x41; uart model asserts tx_done 10 cycles after tx_start. Required: req_ready=4'b0100 for one cycle; tx_start high 10 cycles with tx_data=0x41; grant_id=2; busy returns low once tx_done drops.
2. Round-robin: all four valid continuously, data i=0x30+i. Required: tx_data sequence 0x30,0x31,0x32,0x33,0x30; each req_ready pulses exactly once per round.
3. Pointer wrap: after a grant to 3, valid[1] and valid[3] are both high. Required: 1 is granted before 3 (search starts at 0).
4. Watchdog: TIMEOUT=16, tx_done held 0. Required: tx_start falls after 16 SEND cycles; timeout_err pulses one cycle; next valid is granted normally.
5. Stuck done: tx_done stays high 5 cycles after completion while valid[0]=1. Required: no new tx_start until one cycle after tx_done=0.
6. Async reset: assert rst=0 mid-SEND, between clock edges. Required: tx_start=0 and busy=0 immediately, before the next edge; after release, arbitration restarts from requester 0.
